matrix_storage_reader: RTL and testbench

Read-side sequencer for the layer/row matrix storage that the load-side locator fills. On `start` it walks every stored row, layer 0 row 0 through layer `layer_count-1` row `size-1`. It issues one storage read per row, absorbs the storage's fixed 1-cycle read latency, and presents each row on a valid/ready stream to the compute datapath. A 2-entry output buffer lets the stream run at one row per cycle while still honouring backpressure.

---
 rtl/matrix_storage_reader.sv | 149 ++++++++++++++
 tb/tb_matrix_storage_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_storage_reader.sv
// Read-side sequencer for the layer/row matrix storage.
// Walks every stored row and streams it out through a 2-entry buffer.
module matrix_storage_reader #(
  parameter int size       = 3,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           layer_count,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [31:0]           rd_layer,
  output logic [31:0]           rd_row,
  input  logic [data_width-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic [31:0]           out_layer,
  output logic [31:0]           out_row,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                state;
  logic [31:0]           lc_q;
  logic [31:0]           layer_q;
  logic [31:0]           row_q;

  logic                  inflight;
  logic [31:0]           tag_layer;
  logic [31:0]           tag_row;
  logic                  tag_last;

  logic [data_width-1:0] buf_data  [2];
  logic [31:0]           buf_layer [2];
  logic [31:0]           buf_row   [2];
  logic                  buf_last  [2];
  logic                  head;
  logic [1:0]            occ;

  logic                  pop;
  logic                  push;
  logic                  tail;
  logic                  row_wrap;
  logic                  last_issue;
  logic                  drain_done;

  assign pop  = out_valid && out_ready;
  assign push = inflight;

  // A new read is allowed only if it still fits after this cycle's pop.
  assign rd_en = (state == RUN) &&
    ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});

  assign row_wrap   = (row_q == 32'(size - 1));
  assign last_issue = rd_en && row_wrap && (layer_q == lc_q - 32'd1);
  assign drain_done = !inflight && (occ == {1'b0, pop});

  // Credits keep occ <= 1 whenever a push lands, so tail is head+occ.
  assign tail = head ^ occ[0];

  assign busy      = (state != IDLE);
  assign rd_layer  = layer_q;
  assign rd_row    = row_q;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_data[head];
  assign out_layer = buf_layer[head];
  assign out_row   = buf_row[head];
  assign out_last  = buf_last[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      lc_q      <= '0;
      layer_q   <= '0;
      row_q     <= '0;
      inflight  <= 1'b0;
      tag_layer <= '0;
      tag_row   <= '0;
      tag_last  <= 1'b0;
      head      <= 1'b0;
      occ       <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i]  <= '0;
        buf_layer[i] <= '0;
        buf_row[i]   <= '0;
        buf_last[i]  <= 1'b0;
      end
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;

      if (rd_en) begin
        tag_layer <= layer_q;
        tag_row   <= row_q;
        tag_last  <= last_issue;
        if (row_wrap) begin
          row_q   <= '0;
          layer_q <= layer_q + 32'd1;
        end else begin
          row_q <= row_q + 32'd1;
        end
      end

      if (push) begin
        buf_data[tail]  <= rd_data;
        buf_layer[tail] <= tag_layer;
        buf_row[tail]   <= tag_row;
        buf_last[tail]  <= tag_last;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, pop};

      unique case (state)
        IDLE: begin
          if (start) begin
            if (layer_count != 32'd0) begin
              lc_q    <= layer_count;
              layer_q <= '0;
              row_q   <= '0;
              state   <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_storage_reader.sv
// Bench for matrix_storage_reader: row-order model, per-cycle compare,
// and literal timing checks for each directed pass.
module tb_matrix_storage_reader;

  localparam int SIZE = 3;
  localparam int DW   = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   layer_count;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [31:0]   rd_layer;
  logic [31:0]   rd_row;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_layer;
  logic [31:0]   out_row;
  logic          out_last;

  matrix_storage_reader #(
    .size(SIZE),
    .data_width(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .layer_count(layer_count),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_layer(rd_layer),
    .rd_row(rd_row),
    .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_layer(out_layer),
    .out_row(out_row),
    .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Storage: 1-cycle latency, data = {layer, row}; junk when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= {rd_layer[15:0], rd_row[15:0]};
    else       rd_data <= 32'hdead_beef;
  end

  int ticks = 0;
  always @(posedge clk) ticks <= ticks + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state for the current pass.
  logic          mon_en = 1'b0;
  int            t0;
  int            exp_n;
  int            issued;
  int            popped;
  int            done_cnt;
  int            done_cyc;
  int            busy_cnt;
  int            first_rd, last_rd;
  int            first_hs, last_hs;
  logic          stall_q = 1'b0;
  logic [DW-1:0] data_q;

  function automatic logic [31:0] row_word(input int idx);
    return {16'(idx / SIZE), 16'(idx % SIZE)};
  endfunction

  // Compare process: settled outputs sampled late in every cycle.
  always @(negedge clk) begin
    int k;
    #4;
    if (mon_en) begin
      k = ticks - t0;
      if (rd_en) begin
        chk("rd_overissue", issued < exp_n, 1);
        chk("rd_layer", rd_layer, issued / SIZE);
        chk("rd_row", rd_row, issued % SIZE);
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        issued++;
      end
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, data_q);
      end
      if (out_valid && out_ready) begin
        chk("out_layer", out_layer, popped / SIZE);
        chk("out_row", out_row, popped % SIZE);
        chk("out_data", out_data, row_word(popped));
        chk("out_last", out_last, popped == exp_n - 1);
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        popped++;
      end
      chk("buffered_le2", (issued - popped) <= 2, 1);
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      chk("busy", busy, exp_n > 0 && k >= 1 && done_cnt == 0);
      if (busy) busy_cnt++;
      stall_q = out_valid && !out_ready;
      data_q  = out_data;
    end
  end

  // mode 0: ready high, 1: low in cycles 3..10, 2: random.
  task automatic run_pass(input int lc, input int mode,
                          input bit restart, input int bound);
    int k;
    bit fin;
    @(negedge clk);
    issued   = 0;
    popped   = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    first_rd = -1;
    last_rd  = -1;
    first_hs = -1;
    last_hs  = -1;
    stall_q  = 1'b0;
    exp_n    = lc * SIZE;
    t0       = ticks;
    start       = 1'b1;
    layer_count = 32'(lc);
    out_ready   = 1'b1;
    mon_en      = 1'b1;
    fin = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      k = ticks - t0;
      start       = restart && (k == 2);
      layer_count = start ? 32'd5 : 32'd7;
      unique case (mode)
        1:       out_ready = !(k >= 3 && k <= 10);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (mode == 1 && k == 11) chk("bp_reads_held", issued, 2);
      if (done_cnt > 0 && k > done_cyc + 3) begin
        fin = 1;
        break;
      end
    end
    mon_en = 1'b0;
    start  = 1'b0;
    if (!fin) chk("pass_timeout", 0, 1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_rd_en"}, rd_en, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_heads"},
        out_data | out_layer | out_row | 32'(out_last), 0);
    chk({name, "_addr"}, rd_layer | rd_row, 0);
  endtask

  initial begin
    int k;
    reset       = 1'b1;
    start       = 1'b0;
    layer_count = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full-rate pass, 2 layers.
    run_pass(2, 0, 0, 100);
    chk("full_first_rd", first_rd, 1);
    chk("full_last_rd", last_rd, 6);
    chk("full_first_hs", first_hs, 3);
    chk("full_last_hs", last_hs, 8);
    chk("full_done_cyc", done_cyc, 9);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_rows", popped, 6);

    // Backpressure in cycles 3..10.
    run_pass(2, 1, 0, 100);
    chk("bp_rows", popped, 6);
    chk("bp_done_cyc", done_cyc, 17);
    chk("bp_done_cnt", done_cnt, 1);

    // Zero layers.
    run_pass(0, 0, 0, 50);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy", busy_cnt, 0);
    chk("zero_reads", issued, 0);

    // Second start during RUN must be ignored.
    run_pass(2, 0, 1, 100);
    chk("ign_reads", issued, 6);
    chk("ign_done_cyc", done_cyc, 9);
    chk("ign_done_cnt", done_cnt, 1);

    // Reset in cycle 4 of a full-rate pass.
    @(negedge clk);
    t0          = ticks;
    start       = 1'b1;
    layer_count = 32'd2;
    out_ready   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k = ticks - t0;
      start = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        chk_idle_outputs("midreset");
        reset = 1'b0;
      end
      if (k > 5) chk("midreset_no_done", done, 0);
    end
    run_pass(2, 0, 0, 100);
    chk("restart_first_rd", first_rd, 1);
    chk("restart_rows", popped, 6);
    chk("restart_done_cyc", done_cyc, 9);

    // Random ready over 4 layers.
    run_pass(4, 2, 0, 400);
    chk("rand_rows", popped, 12);
    chk("rand_reads", issued, 12);
    chk("rand_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
